// File: rtl/cpu_control_unit_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Shared types and constants for the accumulator CPU control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  localparam logic [1:0] SRC_B    = 2'b00;
  localparam logic [1:0] SRC_PL   = 2'b01;
  localparam logic [1:0] SRC_PH   = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  typedef struct packed {
    logic n_oe_mem;
    logic n_we_mem;
    logic n_oe_d_di;
    logic we_ir;
    logic inc_ip;
    logic addr_dp;
    logic p_selector;
    logic n_we_pl;
    logic n_we_ph;
    logic we_a;
    logic we_b;
    logic n_oe_pl_alu;
    logic n_oe_ph_alu;
    logic n_oe_b_alu;
    logic n_oe_a_d;
    logic n_oe_b_d;
    logic n_we_flags;
    logic n_oe_alu_di;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    n_oe_mem:    1'b1,
    n_we_mem:    1'b1,
    n_oe_d_di:   1'b1,
    we_ir:       1'b0,
    inc_ip:      1'b0,
    addr_dp:     1'b0,
    p_selector:  1'b0,
    n_we_pl:     1'b1,
    n_we_ph:     1'b1,
    we_a:        1'b0,
    we_b:        1'b0,
    n_oe_pl_alu: 1'b1,
    n_oe_ph_alu: 1'b1,
    n_oe_b_alu:  1'b1,
    n_oe_a_d:    1'b1,
    n_oe_b_d:    1'b1,
    n_we_flags:  1'b1,
    n_oe_alu_di: 1'b1
  };

endpackage

`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
// ============================================================================
// Module  : cpu_ctrl_if
// Brief   : IR/flags/ready inputs and datapath enables of the control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_ctrl_if;
  logic [7:0] ir;
  logic [3:0] flags;
  logic       n_mem_rdy;
  logic       n_oe_mem;
  logic       n_we_mem;
  logic       n_oe_d_di;
  logic       we_ir;
  logic       inc_ip;
  logic       addr_dp;
  logic       p_selector;
  logic       n_we_pl;
  logic       n_we_ph;
  logic       we_a;
  logic       we_b;
  logic       n_oe_pl_alu;
  logic       n_oe_ph_alu;
  logic       n_oe_b_alu;
  logic       n_oe_a_d;
  logic       n_oe_b_d;
  logic       n_we_flags;
  logic       n_oe_alu_di;

  modport master (
    input  ir, flags, n_mem_rdy,
    output n_oe_mem, n_we_mem, n_oe_d_di, we_ir, inc_ip, addr_dp, p_selector,
           n_we_pl, n_we_ph, we_a, we_b, n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu,
           n_oe_a_d, n_oe_b_d, n_we_flags, n_oe_alu_di
  );

  modport slave (
    output ir, flags, n_mem_rdy,
    input  n_oe_mem, n_we_mem, n_oe_d_di, we_ir, inc_ip, addr_dp, p_selector,
           n_we_pl, n_we_ph, we_a, we_b, n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu,
           n_oe_a_d, n_oe_b_d, n_we_flags, n_oe_alu_di
  );
endinterface

`default_nettype wire

// File: rtl/cpu_control_unit_decode.sv
// ============================================================================
// Module  : cpu_ctrl_decode
// Brief   : Combinational decode of state, IR, flags and ready into enables.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  wire logic   i_active,
  input  state_t      i_state,
  input  wire logic [7:0] i_ir,
  input  wire logic [3:0] i_flags,
  input  wire logic   i_n_mem_rdy,
  output ctrl_t       o_ctrl,
  output state_t      o_next
);

  logic w_rdy;
  logic w_cond;
  logic w_unused_ir;

  assign w_rdy       = ~i_n_mem_rdy;
  assign w_cond      = i_flags[i_ir[1:0]] ^ i_ir[2];
  // ALU opcode bits are consumed by the ALU, not by the sequencer
  assign w_unused_ir = ^i_ir[4:3];

  always_comb begin
    o_ctrl = CTRL_IDLE;
    o_next = FETCH;
    if (i_active) begin
      if (i_state == FETCH) begin
        o_ctrl.n_oe_mem = 1'b0;
        o_ctrl.we_ir    = w_rdy;
        o_ctrl.inc_ip   = w_rdy;
        o_next          = w_rdy ? EXEC : FETCH;
      end else if (!i_ir[7]) begin
        o_ctrl.n_oe_b_alu  = (i_ir[1:0] != SRC_B);
        o_ctrl.n_oe_pl_alu = (i_ir[1:0] != SRC_PL);
        o_ctrl.n_oe_ph_alu = (i_ir[1:0] != SRC_PH);
        o_ctrl.n_oe_alu_di = 1'b0;
        o_ctrl.we_a        = 1'b1;
        o_ctrl.n_we_flags  = 1'b0;
      end else begin
        case (i_ir[7:5])
          OP_LD: begin
            o_ctrl.addr_dp   = 1'b1;
            o_ctrl.n_oe_mem  = 1'b0;
            o_ctrl.n_oe_d_di = 1'b0;
            o_ctrl.we_a      = w_rdy & ~i_ir[0];
            o_ctrl.we_b      = w_rdy &  i_ir[0];
            o_next           = w_rdy ? FETCH : EXEC;
          end
          OP_ST: begin
            o_ctrl.addr_dp  = 1'b1;
            o_ctrl.n_oe_a_d = i_ir[0];
            o_ctrl.n_oe_b_d = ~i_ir[0];
            o_ctrl.n_we_mem = 1'b0;
            o_next          = w_rdy ? FETCH : EXEC;
          end
          OP_LDI: begin
            o_ctrl.n_oe_mem  = 1'b0;
            o_ctrl.n_oe_d_di = 1'b0;
            o_ctrl.n_we_pl   = ~(w_rdy & ~i_ir[0]);
            o_ctrl.n_we_ph   = ~(w_rdy &  i_ir[0]);
            o_ctrl.inc_ip    = w_rdy;
            o_next           = w_rdy ? FETCH : EXEC;
          end
          default: begin
            o_ctrl.p_selector = w_cond;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// Module  : cpu_control_unit
// Brief   : FETCH/EXEC sequencer of the 8-bit accumulator CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
  import cpu_ctrl_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   n_rst,
  cpu_ctrl_if.master  bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset gates the decoder so an interrupted access issues no strobe
  cpu_ctrl_decode u_decode (
    .i_active    (n_rst),
    .i_state     (r_state),
    .i_ir        (bus.ir),
    .i_flags     (bus.flags),
    .i_n_mem_rdy (bus.n_mem_rdy),
    .o_ctrl      (w_ctrl),
    .o_next      (w_next)
  );

  assign bus.n_oe_mem    = w_ctrl.n_oe_mem;
  assign bus.n_we_mem    = w_ctrl.n_we_mem;
  assign bus.n_oe_d_di   = w_ctrl.n_oe_d_di;
  assign bus.we_ir       = w_ctrl.we_ir;
  assign bus.inc_ip      = w_ctrl.inc_ip;
  assign bus.addr_dp     = w_ctrl.addr_dp;
  assign bus.p_selector  = w_ctrl.p_selector;
  assign bus.n_we_pl     = w_ctrl.n_we_pl;
  assign bus.n_we_ph     = w_ctrl.n_we_ph;
  assign bus.we_a        = w_ctrl.we_a;
  assign bus.we_b        = w_ctrl.we_b;
  assign bus.n_oe_pl_alu = w_ctrl.n_oe_pl_alu;
  assign bus.n_oe_ph_alu = w_ctrl.n_oe_ph_alu;
  assign bus.n_oe_b_alu  = w_ctrl.n_oe_b_alu;
  assign bus.n_oe_a_d    = w_ctrl.n_oe_a_d;
  assign bus.n_oe_b_d    = w_ctrl.n_oe_b_d;
  assign bus.n_we_flags  = w_ctrl.n_we_flags;
  assign bus.n_oe_alu_di = w_ctrl.n_oe_alu_di;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
// Module  : tb_cpu_control_unit
// Brief   : Self-checking bench for cpu_control_unit against a rule model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  bit   m_exec;

  localparam logic [17:0] IDLE = 18'b111_0000_11_00_111_11_11;

  cpu_ctrl_if bus ();

  cpu_control_unit dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] act();
    return {bus.n_oe_mem, bus.n_we_mem, bus.n_oe_d_di, bus.we_ir, bus.inc_ip,
            bus.addr_dp, bus.p_selector, bus.n_we_pl, bus.n_we_ph, bus.we_a,
            bus.we_b, bus.n_oe_pl_alu, bus.n_oe_ph_alu, bus.n_oe_b_alu,
            bus.n_oe_a_d, bus.n_oe_b_d, bus.n_we_flags, bus.n_oe_alu_di};
  endfunction

  // Each enable written as the set of situations in which it must be asserted
  function automatic logic [17:0] model();
    bit f, x, rdy, alu, ld, st, ldi, jmp, b0, cond;
    int op, src;
    f   = n_rst && !m_exec;
    x   = n_rst && m_exec;
    rdy = (bus.n_mem_rdy == 1'b0);
    op  = int'(bus.ir) / 32;
    src = int'(bus.ir) % 4;
    b0  = bus.ir[0];
    alu = x && op < 4;
    ld  = x && op == 4;
    st  = x && op == 5;
    ldi = x && op == 6;
    jmp = x && op == 7;
    cond = bus.flags[src] != bus.ir[2];
    return {!(f || ld || ldi), !st, !(ld || ldi), f && rdy, (f || ldi) && rdy,
            ld || st, jmp && cond, !(ldi && rdy && !b0), !(ldi && rdy && b0),
            alu || (ld && rdy && !b0), ld && rdy && b0,
            !(alu && src == 1), !(alu && src == 2), !(alu && src == 0),
            !(st && !b0), !(st && b0), !alu, !alu};
  endfunction

  function automatic bit model_next();
    int op;
    op = int'(bus.ir) / 32;
    if (!n_rst) return 1'b0;
    if (!m_exec) return bus.n_mem_rdy == 1'b0;
    if (op >= 4 && op <= 6) return bus.n_mem_rdy == 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic r, input logic [7:0] i, input logic [3:0] fl,
                       input logic rdy);
    n_rst = r;
    bus.ir = i;
    bus.flags = fl;
    bus.n_mem_rdy = rdy;
  endtask

  task automatic tick();
    bit nx;
    nx = model_next();
    @(posedge clk);
    m_exec = nx;
    #1;
  endtask

  task automatic go_exec(input logic [7:0] i);
    drive(1'b1, i, 4'h0, 1'b0);
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h81, 4'hF, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (act() !== IDLE) begin
      failures++;
      $display("FAIL reset_idle act=%b exp=%b", act(), IDLE);
    end
    tick();
    drive(1'b1, 8'h00, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.n_oe_mem, bus.addr_dp, bus.we_ir} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_fetch act=%b exp=000", {bus.n_oe_mem, bus.addr_dp, bus.we_ir});
    end
    tick();
  endtask

  task automatic test_fetch_wait();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'hE0, 4'h0, (c < 2) ? 1'b1 : 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.we_ir, bus.inc_ip, bus.n_oe_mem} !== ((c < 2) ? 3'b000 : 3'b110)) begin
        failures++;
        $display("FAIL fetch_wait_c%0d act=%b exp=%b", c,
                 {bus.we_ir, bus.inc_ip, bus.n_oe_mem}, (c < 2) ? 3'b000 : 3'b110);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.we_ir, bus.n_oe_mem} !== 2'b01) begin
      failures++;
      $display("FAIL fetch_then_exec act=%b exp=01", {bus.we_ir, bus.n_oe_mem});
    end
    tick();
  endtask

  task automatic test_alu();
    go_exec(8'h01);
    drive(1'b1, 8'h01, 4'($urandom), 1'($urandom));
    @(negedge clk);
    checks++;
    if ({bus.n_oe_pl_alu, bus.n_oe_alu_di, bus.we_a, bus.n_we_flags, bus.n_oe_b_alu,
         bus.n_oe_ph_alu} !== 6'b001011) begin
      failures++;
      $display("FAIL alu_pl act=%b exp=001011", {bus.n_oe_pl_alu, bus.n_oe_alu_di,
               bus.we_a, bus.n_we_flags, bus.n_oe_b_alu, bus.n_oe_ph_alu});
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      logic [7:0] i;
      i = 8'((($urandom % 16) << 3) | (s % 4)) & 8'h7F;
      drive(1'b1, i, 4'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (act() !== model()) begin
        failures++;
        $display("FAIL alu_fetch_%0d act=%b exp=%b", s, act(), model());
      end
      tick();
      drive(1'b1, i, 4'($urandom), 1'($urandom));
      @(negedge clk);
      checks++;
      if (act() !== model()) begin
        failures++;
        $display("FAIL alu_src_%0d ir=%h act=%b exp=%b", s, i, act(), model());
      end
      tick();
    end
  endtask

  task automatic test_ld_st();
    go_exec(8'h81);
    drive(1'b1, 8'h81, 4'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.addr_dp, bus.n_oe_mem, bus.n_oe_d_di, bus.we_b, bus.we_a} !== 5'b10010) begin
      failures++;
      $display("FAIL ld_b act=%b exp=10010", {bus.addr_dp, bus.n_oe_mem, bus.n_oe_d_di,
               bus.we_b, bus.we_a});
    end
    tick();
    go_exec(8'hA0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'hA0, 4'h0, (c < 2) ? 1'b1 : 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.addr_dp, bus.n_oe_a_d, bus.n_we_mem, bus.n_oe_mem, bus.n_oe_b_d} !== 5'b10011) begin
        failures++;
        $display("FAIL st_a_c%0d act=%b exp=10011", c, {bus.addr_dp, bus.n_oe_a_d,
                 bus.n_we_mem, bus.n_oe_mem, bus.n_oe_b_d});
      end
      tick();
    end
    drive(1'b1, 8'h00, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.n_oe_mem, bus.addr_dp, bus.n_we_mem} !== 3'b001) begin
      failures++;
      $display("FAIL st_back_to_fetch act=%b exp=001", {bus.n_oe_mem, bus.addr_dp, bus.n_we_mem});
    end
    tick();
  endtask

  task automatic test_ldi();
    go_exec(8'hC1);
    drive(1'b1, 8'hC1, 4'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.n_we_ph, bus.n_we_pl, bus.inc_ip, bus.addr_dp, bus.n_oe_mem} !== 5'b01100) begin
      failures++;
      $display("FAIL ldi_ph act=%b exp=01100", {bus.n_we_ph, bus.n_we_pl, bus.inc_ip,
               bus.addr_dp, bus.n_oe_mem});
    end
    tick();
  endtask

  task automatic test_jmp();
    logic [7:0] t_ir [4] = '{8'hE0, 8'hE0, 8'hE4, 8'hE3};
    logic [3:0] t_fl [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000};
    logic       t_ps [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      go_exec(t_ir[k]);
      drive(1'b1, t_ir[k], t_fl[k], 1'($urandom));
      @(negedge clk);
      checks++;
      if (bus.p_selector !== t_ps[k]) begin
        failures++;
        $display("FAIL jmp_%0d p_selector act=%b exp=%b", k, bus.p_selector, t_ps[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    go_exec(8'h80);
    drive(1'b1, 8'h80, 4'h0, 1'b1);
    @(negedge clk);
    tick();
    drive(1'b0, 8'h80, 4'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (act() !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_wait act=%b exp=%b", act(), IDLE);
    end
    tick();
    drive(1'b1, 8'h80, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.n_oe_mem, bus.addr_dp, bus.n_oe_d_di} !== 3'b001) begin
      failures++;
      $display("FAIL reset_mid_wait_fetch act=%b exp=001", {bus.n_oe_mem, bus.addr_dp, bus.n_oe_d_di});
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 16) != 0, 8'($urandom), 4'($urandom), ($urandom % 5) < 2);
      @(negedge clk);
      checks++;
      if (act() !== model()) begin
        failures++;
        $display("FAIL random_c%0d ir=%h fl=%h rdy=%b act=%b exp=%b", c, bus.ir,
                 bus.flags, bus.n_mem_rdy, act(), model());
      end
      checks++;
      if ((!bus.n_oe_d_di && !bus.n_oe_alu_di) || (!bus.n_oe_mem && !bus.n_we_mem) ||
          (int'(!bus.n_oe_b_alu) + int'(!bus.n_oe_pl_alu) + int'(!bus.n_oe_ph_alu) > 1)) begin
        failures++;
        $display("FAIL random_exclusive_c%0d act=%b exp=no_conflict", c, act());
      end
      tick();
    end
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    m_exec = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b1);
    #1;
    test_reset();
    test_fetch_wait();
    test_alu();
    test_ld_st();
    test_ldi();
    test_jmp();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Microcoded-free control sequencer of the 8-bit accumulator CPU. Fetches an opcode into IR, decodes IR and flags, and drives every bus-enable and write-strobe of the datapath (memory, A/B registers, pointer pair, ALU, flags). It sits between the IR/flags registers and the datapath enables, with memory wait-state support via n_mem_rdy.

Parameters:
none (fixed 8-bit IR, 4-bit flags)

Ports:
clk  in  1  system clock; state advances on rising edge
n_rst  in  1  reset, synchronous, active-low
ir  in  8  current instruction register
flags  in  4  flags register: [0]=Z, [1]=C, [2]=S, [3]=O
n_mem_rdy  in  1  memory ready, active-low
n_oe_mem, n_we_mem  out  1 each  memory read/write strobes, active-low
n_oe_d_di  out  1  external bus -> internal bus, active-low
we_ir  out  1  IR write enable
inc_ip  out  1  increment IP
addr_dp  out  1  address source: 0=IP, 1=DP
p_selector  out  1  pointer-pair swap/select pulse
n_we_pl, n_we_ph  out  1 each  pointer low/high byte write, active-low
we_a, we_b  out  1 each  A/B register write enables
n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu  out  1 each  ALU-B operand source, active-low
n_oe_a_d, n_oe_b_d  out  1 each  A/B onto external bus, active-low
n_we_flags  out  1  flags load, active-low
n_oe_alu_di  out  1  ALU result onto internal bus, active-low

Behaviour:
- One clock; reset is synchronous and active-low (clk, n_rst). Rising clk with n_rst=0 -> state FETCH.
- While n_rst=0, all outputs inactive: active-low outputs 1, active-high outputs 0, addr_dp=0.
- Outputs are combinational from (state, ir, flags, n_mem_rdy); state is registered.
- Idle defaults: every enable inactive, addr_dp=0.
- States: FETCH, EXEC.
- FETCH: addr_dp=0, n_oe_mem=0, n_oe_d_di=1. If n_mem_rdy=0: we_ir=1, inc_ip=1, next EXEC; else stay FETCH (wait state, no strobes).
- EXEC decode on ir[7:5]:
  * 0xx ALU (op=ir[6:3], invert=ir[2] consumed by ALU): operand B source ir[1:0]: 00 n_oe_b_alu=0, 01 n_oe_pl_alu=0, 10 n_oe_ph_alu=0, 11 none (zero). n_oe_alu_di=0, we_a=1, n_we_flags=0. One cycle -> FETCH.
  * 100 LD: addr_dp=1, n_oe_mem=0, n_oe_d_di=0; when n_mem_rdy=0: we_a (ir[0]=0) or we_b (ir[0]=1) =1, -> FETCH; else stay EXEC.
  * 101 ST: addr_dp=1, n_oe_a_d=0 (ir[0]=0) or n_oe_b_d=0 (ir[0]=1), n_we_mem=0; hold until n_mem_rdy=0, then -> FETCH.
  * 110 LDI: addr_dp=0, n_oe_mem=0, n_oe_d_di=0; when n_mem_rdy=0: n_we_pl=0 (ir[0]=0) or n_we_ph=0 (ir[0]=1), inc_ip=1, -> FETCH.
  * 111 JMP: cond = flags[ir[1:0]] XOR ir[2]. If cond=1: p_selector=1 for this cycle. One cycle -> FETCH.
- n_oe_d_di=0 and n_oe_alu_di=0 are never simultaneous; n_oe_mem=0 and n_we_mem=0 never simultaneous; at most one of the three ALU-B sources active.
- Reset asserted mid-wait aborts the access; no strobe issued in that cycle.

Decomposition:
- Package cpu_ctrl_pkg: state enum (FETCH, EXEC), opcode-class constants (OP_LD=3'b100, OP_ST=3'b101, OP_LDI=3'b110, OP_JMP=3'b111), flag bit indices (FLAG_Z..FLAG_O), ALU-B source codes.
- One sub-module natural: cpu_ctrl_decode (purely combinational: state, ir, flags, n_mem_rdy -> all enables); top holds the state register.

Test Plan:
- Reset: n_rst=0 for 2 clocks -> all active-low outputs 1, active-high outputs 0; release -> FETCH with n_oe_mem=0, addr_dp=0.
- Fetch with 2 wait states: n_mem_rdy=1 for 2 cycles then 0 -> we_ir/inc_ip pulse only in the ready cycle, then EXEC.
- ALU ir=8'h01 (op0, source PL) -> n_oe_pl_alu=0, n_oe_alu_di=0, we_a=1, n_we_flags=0 for one cycle, then FETCH.
- LD ir=8'h81 with rdy low -> addr_dp=1, n_oe_mem=0, n_oe_d_di=0, we_b=1; ST ir=8'hA0 -> n_oe_a_d=0, n_we_mem=0 held until rdy.
- LDI ir=8'hC1 -> n_we_ph=0 and inc_ip=1 with addr_dp=0.
- JMP ir=8'hE0 with flags=4'b0001 -> p_selector=1; flags=4'b0000 -> p_selector=0; ir=8'hE4 with flags=4'b0000 -> p_selector=1.
